// File: rtl/sevenseg_scan.sv
// sevenseg_scan: time-multiplexed driver for a common-anode, active-low
// multi-digit seven-segment display. One digit is lit per slot, each slot
// opens with a blanking gap, and the segment vector is latched once per frame
// so a software write can never tear a frame that is already on the glass.
// Optional build macro: SEVENSEG_BRIGHTNESS_EN adds a 4-bit brightness input
// that PWM-gates the ON phase of every slot (0 = dark, 15 = 15/16 duty).
module sevenseg_scan #(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef SEVENSEG_BRIGHTNESS_EN
  input  logic [3:0]              brightness,
`endif
  input  logic [7*NUM_DIGITS-1:0] sevenseg,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [6:0]              seg_n
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CW-1:0]             cyc_q, cyc_d;
  logic [DW-1:0]             dig_q, dig_d;
  logic [7*NUM_DIGITS-1:0]   frame_q, frame_d;
  logic [NUM_DIGITS-1:0]     an_n_q, an_n_d;
  logic [6:0]                seg_n_q, seg_n_d;
  logic                      slot_end;
  logic                      frame_end;
  logic                      lit;
  int                        seg_base;

`ifdef SEVENSEG_BRIGHTNESS_EN
  logic [3:0]                bright_q, bright_d;
  logic [3:0]                pwm_q, pwm_d;
`endif

  // Next-state for the scan counters and frame latch; outputs are derived
  // from the next state so the output flops line up with the state flops.
  always_comb begin
    slot_end  = (cyc_q == CW'(DIGIT_CYCLES - 1));
    frame_end = slot_end && (dig_q == DW'(NUM_DIGITS - 1));
    cyc_d     = slot_end ? '0 : cyc_q + CW'(1);
    dig_d     = dig_q;
    frame_d   = frame_q;
    if (slot_end) begin
      dig_d = (dig_q == DW'(NUM_DIGITS - 1)) ? '0 : dig_q + DW'(1);
    end
    if (frame_end) begin
      frame_d = sevenseg;
    end

`ifdef SEVENSEG_BRIGHTNESS_EN
    bright_d = frame_end ? brightness : bright_q;
    pwm_d    = (cyc_d == CW'(BLANK_CYCLES)) ? 4'd0 : pwm_q + 4'd1;
    lit      = (cyc_d >= CW'(BLANK_CYCLES)) && (pwm_d < bright_d);
`else
    lit      = (cyc_d >= CW'(BLANK_CYCLES));
`endif

    seg_base = 7 * int'(dig_d);
    an_n_d   = '1;
    seg_n_d  = 7'h7F;
    if (lit) begin
      an_n_d[dig_d] = 1'b0;
      seg_n_d       = ~frame_d[seg_base +: 7];
    end
  end

  // State and output registers; reset darkens the display and restarts at slot 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q    <= '0;
      dig_q    <= '0;
      frame_q  <= '0;
      an_n_q   <= '1;
      seg_n_q  <= 7'h7F;
`ifdef SEVENSEG_BRIGHTNESS_EN
      bright_q <= 4'hF;
      pwm_q    <= 4'd0;
`endif
    end else begin
      cyc_q    <= cyc_d;
      dig_q    <= dig_d;
      frame_q  <= frame_d;
      an_n_q   <= an_n_d;
      seg_n_q  <= seg_n_d;
`ifdef SEVENSEG_BRIGHTNESS_EN
      bright_q <= bright_d;
      pwm_q    <= pwm_d;
`endif
    end
  end

  assign an_n  = an_n_q;
  assign seg_n = seg_n_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: scoreboard bench for sevenseg_scan with an 8-digit,
// 10-cycle slot, 2-cycle blank configuration (80-cycle frame). The stimulus
// process tracks the expected scan position and pushes the expected display
// for every cycle; a monitor pops and compares on the falling edge.
// Build with SEVENSEG_BRIGHTNESS_EN to also exercise the PWM brightness path.
module tb_sevenseg_scan;

  localparam int ND = 8;
  localparam int DC = 10;
  localparam int BC = 2;

  typedef struct {
    logic [ND-1:0] an;
    logic [6:0]    seg;
    int            slot;
    int            cyc;
  } exp_t;

  logic            clk;
  logic            reset;
  logic [7*ND-1:0] sevenseg;
  logic [ND-1:0]   an_n;
  logic [6:0]      seg_n;
`ifdef SEVENSEG_BRIGHTNESS_EN
  logic [3:0]      brightness;
`endif

  exp_t            expQ[$];
  int              total;
  int              bad;
  int              tSlot;
  int              tCyc;
  logic [7*ND-1:0] shownFrame;
  logic [3:0]      shownBright;

  sevenseg_scan #(
    .NUM_DIGITS  (ND),
    .DIGIT_CYCLES(DC),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef SEVENSEG_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .sevenseg  (sevenseg),
    .an_n      (an_n),
    .seg_n     (seg_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected display for a given scan position, frame and brightness.
  function automatic void calcExpected(input int slot, input int cyc,
                                       input logic [7*ND-1:0] fr,
                                       input logic [3:0] br,
                                       output logic [ND-1:0] an,
                                       output logic [6:0] seg);
    logic on;
    an  = '1;
    seg = 7'h7F;
    on  = (cyc >= BC);
`ifdef SEVENSEG_BRIGHTNESS_EN
    on  = on && ((cyc - BC) < int'(br));
`endif
    if (on) begin
      an[slot] = 1'b0;
      seg      = ~fr[7*slot +: 7];
    end
  endfunction

  // Advance the bench's view of the scan by n clock edges, pushing the
  // expected outputs for each new cycle.
  task automatic applyStimulus(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (reset) begin
        tSlot       = 0;
        tCyc        = 0;
        shownFrame  = '0;
        shownBright = 4'hF;
      end else if (tCyc == DC - 1) begin
        tCyc = 0;
        if (tSlot == ND - 1) begin
          tSlot      = 0;
          shownFrame = sevenseg;
`ifdef SEVENSEG_BRIGHTNESS_EN
          shownBright = brightness;
`endif
        end else begin
          tSlot = tSlot + 1;
        end
      end else begin
        tCyc = tCyc + 1;
      end
      calcExpected(tSlot, tCyc, shownFrame, shownBright, e.an, e.seg);
      e.slot = tSlot;
      e.cyc  = tCyc;
      expQ.push_back(e);
    end
  endtask

  // Step until the scan reaches the requested position, bounded.
  task automatic runUntil(input int slot, input int cyc);
    for (int i = 0; i < 200 && !(tSlot == slot && tCyc == cyc); i++) begin
      applyStimulus(1);
    end
    if (!(tSlot == slot && tCyc == cyc)) begin
      total = total + 1;
      bad   = bad + 1;
      $display("[TB] FAIL runUntil: reached slot=%0d cyc=%0d, wanted slot=%0d cyc=%0d",
               tSlot, tCyc, slot, cyc);
    end
  endtask

  // Compare one popped expectation against the DUT outputs.
  task automatic checkOutput(input exp_t e);
    total = total + 1;
    if (an_n !== e.an || seg_n !== e.seg) begin
      bad = bad + 1;
      $display("[TB] FAIL scan slot=%0d cyc=%0d: an_n got=%h want=%h, seg_n got=%h want=%h",
               e.slot, e.cyc, an_n, e.an, seg_n, e.seg);
    end
  endtask

  // Monitor: one expectation per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      checkOutput(expQ.pop_front());
    end
  end

  initial begin
    total       = 0;
    bad         = 0;
    tSlot       = 0;
    tCyc        = 0;
    shownFrame  = '0;
    shownBright = 4'hF;
    reset       = 1'b1;
    sevenseg    = '1;
`ifdef SEVENSEG_BRIGHTNESS_EN
    brightness  = 4'hF;
`endif

    $display("[TB] reset held with all segments requested");
    applyStimulus(3);
    reset = 1'b0;

    $display("[TB] digit0=3F queued; first frame dark, second shows it");
    sevenseg = 56'h3F;
    applyStimulus(80 + 33);

    $display("[TB] digit0 changed to 06 mid-frame");
    sevenseg = 56'h06;
    applyStimulus(47 + 80 + 5);

    $display("[TB] reset pulse in slot 5 ON phase");
    runUntil(5, 6);
    reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0;
    sevenseg = {7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
    applyStimulus(160 + 5);

`ifdef SEVENSEG_BRIGHTNESS_EN
    $display("[TB] brightness 4 then 0");
    brightness = 4'd4;
    applyStimulus(160);
    brightness = 4'd0;
    applyStimulus(160);
`endif

    for (int i = 0; i < 5 && expQ.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (expQ.size() > 0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("[TB] FAIL drain: pending=%0d want=0", expQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
